// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: controller state encodings and the
// default wrap limits of the minute and second fields.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJ    = 2'd2
    } state_t;

    localparam int WRAP_MIN_DEF = 59;
    localparam int WRAP_SEC_DEF = 59;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter that wraps to 00 after WRAP; carry flags the wrapping increment.
module bcd_mod60_counter
    import stopwatch_pkg::*;
#(
    parameter int WRAP = WRAP_SEC_DEF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       carry
);

    localparam logic [3:0] WRAP_T = 4'(WRAP / 10);
    localparam logic [3:0] WRAP_O = 4'(WRAP % 10);

    logic at_wrap;

    // Next BCD value with decimal carry from ones into tens and wrap to 00 at the limit.
    function automatic logic [7:0] bcd_step(input logic [3:0] t, input logic [3:0] o,
                                            input logic wrap);
        if (wrap)
            return 8'h00;
        else if (o == 4'd9)
            return {t + 4'd1, 4'd0};
        else
            return {t, o + 4'd1};
    endfunction

    assign at_wrap = (tens == WRAP_T) && (ones == WRAP_O);
    assign carry   = inc && at_wrap;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tens <= 4'd0;
            ones <= 4'd0;
        end else if (inc) begin
            {tens, ones} <= bcd_step(tens, ones, at_wrap);
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch: counts on 1 Hz ticks in RUN, holds in PAUSED, and steps the
// selected field on 2 Hz ticks in ADJ with blink-driven field blanking.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int WRAP_MIN = WRAP_MIN_DEF,
    parameter int WRAP_SEC = WRAP_SEC_DEF
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       onehz_clk,
    input  logic       twohz_clk,
    input  logic       blink_clk,
    input  logic       pause,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       blank_min,
    output logic       blank_sec,
    output logic       running
);

    state_t state;
    logic   onehz_p1, twohz_p1;
    logic   tick_1hz, tick_2hz;
    logic   run_tick, adj_tick;
    logic   sec_inc, min_inc;
    logic   sec_carry, min_carry_unused;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            onehz_p1 <= 1'b0;
            twohz_p1 <= 1'b0;
        end else begin
            onehz_p1 <= onehz_clk;
            twohz_p1 <= twohz_clk;
        end
    end

    assign tick_1hz = onehz_clk & ~onehz_p1;
    assign tick_2hz = twohz_clk & ~twohz_p1;

    // A 1 Hz tick that coincides with adj rising is dropped: the block is leaving RUN.
    assign run_tick = (state == RUN) && !adj && tick_1hz;
    assign adj_tick = (state == ADJ) && tick_2hz;
    assign sec_inc  = run_tick || (adj_tick && sel);
    assign min_inc  = (run_tick && sec_carry) || (adj_tick && !sel);

    bcd_mod60_counter #(.WRAP(WRAP_SEC)) u_sec (
        .sys_clk (sys_clk),
        .rst     (rst),
        .inc     (sec_inc),
        .tens    (sec_tens),
        .ones    (sec_ones),
        .carry   (sec_carry)
    );

    bcd_mod60_counter #(.WRAP(WRAP_MIN)) u_min (
        .sys_clk (sys_clk),
        .rst     (rst),
        .inc     (min_inc),
        .tens    (min_tens),
        .ones    (min_ones),
        .carry   (min_carry_unused)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state     <= RUN;
            running   <= 1'b1;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            blank_min <= (state == ADJ) && !sel && blink_clk;
            blank_sec <= (state == ADJ) && sel && blink_clk;
            case (state)
                RUN: begin
                    if (adj) begin
                        state   <= ADJ;
                        running <= 1'b0;
                    end else if (pause) begin
                        state   <= PAUSED;
                        running <= 1'b0;
                    end
                end
                PAUSED: begin
                    if (adj) begin
                        state <= ADJ;
                    end else if (pause) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                ADJ: begin
                    if (!adj)
                        state <= PAUSED;
                end
                default: begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios with literal expectations plus
// randomized stimulus, all compared each cycle against a time-arithmetic model.
module tb_stopwatch_counter;

    localparam int WRAP_MIN = 59;
    localparam int WRAP_SEC = 59;
    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_ADJ    = 2;

    logic       sys_clk   = 1'b0;
    logic       rst       = 1'b1;
    logic       onehz_clk = 1'b0;
    logic       twohz_clk = 1'b0;
    logic       blink_clk = 1'b0;
    logic       pause     = 1'b0;
    logic       adj       = 1'b0;
    logic       sel       = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       blank_min, blank_sec, running;

    int n_pass  = 0;
    int n_total = 0;

    // Model state: elapsed minutes/seconds, mode, previous tick-input levels.
    int   mm       = 0;
    int   ss       = 0;
    int   mode     = M_RUN;
    logic prev1    = 1'b0;
    logic prev2    = 1'b0;
    logic exp_bmin = 1'b0;
    logic exp_bsec = 1'b0;
    bit   model_ok = 1'b0;

    always #5 sys_clk = ~sys_clk;

    stopwatch_counter #(.WRAP_MIN(WRAP_MIN), .WRAP_SEC(WRAP_SEC)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .onehz_clk (onehz_clk),
        .twohz_clk (twohz_clk),
        .blink_clk (blink_clk),
        .pause     (pause),
        .adj       (adj),
        .sel       (sel),
        .min_tens  (min_tens),
        .min_ones  (min_ones),
        .sec_tens  (sec_tens),
        .sec_ones  (sec_ones),
        .blank_min (blank_min),
        .blank_sec (blank_sec),
        .running   (running)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] bcd4(input int m, input int s);
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] dut_digits();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    // Reference model advanced on each rising edge, compared 1 time unit later.
    always @(posedge sys_clk) begin
        bit t1, t2;
        int total;
        if (rst) begin
            mm       = 0;
            ss       = 0;
            mode     = M_RUN;
            prev1    = 1'b0;
            prev2    = 1'b0;
            exp_bmin = 1'b0;
            exp_bsec = 1'b0;
            model_ok = 1'b1;
        end else begin
            t1    = onehz_clk && !prev1;
            t2    = twohz_clk && !prev2;
            prev1 = onehz_clk;
            prev2 = twohz_clk;
            exp_bmin = (mode == M_ADJ) && !sel && blink_clk;
            exp_bsec = (mode == M_ADJ) && sel && blink_clk;
            if (mode == M_RUN && !adj && t1) begin
                total = (mm * (WRAP_SEC + 1) + ss + 1) % ((WRAP_MIN + 1) * (WRAP_SEC + 1));
                mm    = total / (WRAP_SEC + 1);
                ss    = total % (WRAP_SEC + 1);
            end
            if (mode == M_ADJ && t2) begin
                if (sel) ss = (ss + 1) % (WRAP_SEC + 1);
                else     mm = (mm + 1) % (WRAP_MIN + 1);
            end
            if (mode != M_ADJ && adj)
                mode = M_ADJ;
            else if (mode == M_ADJ) begin
                if (!adj) mode = M_PAUSED;
            end else if (pause)
                mode = (mode == M_RUN) ? M_PAUSED : M_RUN;
        end
        #1;
        if (model_ok) begin
            check("model_digits", dut_digits(), bcd4(mm, ss));
            check("model_running", 16'(running), 16'(mode == M_RUN));
            check("model_blank_min", 16'(blank_min), 16'(exp_bmin));
            check("model_blank_sec", 16'(blank_sec), 16'(exp_bsec));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse1hz(input int n);
        repeat (n) begin
            onehz_clk = 1'b1; cyc(2);
            onehz_clk = 1'b0; cyc(2);
        end
    endtask

    task automatic pulse2hz(input int n);
        repeat (n) begin
            twohz_clk = 1'b1; cyc(2);
            twohz_clk = 1'b0; cyc(2);
        end
    endtask

    task automatic pulse_pause();
        pause = 1'b1; cyc(1);
        pause = 1'b0; cyc(1);
    endtask

    task automatic lit(input string name, input logic [15:0] digits, input logic run);
        check({name, "_digits"}, dut_digits(), digits);
        check({name, "_running"}, 16'(running), 16'(run));
    endtask

    initial begin
        cyc(2);
        rst = 1'b0;
        lit("reset", 16'h0000, 1'b1);
        check("reset_blank_min", 16'(blank_min), 16'h0);
        check("reset_blank_sec", 16'(blank_sec), 16'h0);

        // adj rising together with a 1 Hz edge: enter ADJ, tick dropped
        adj = 1'b1; onehz_clk = 1'b1; cyc(2);
        lit("adj_tick", 16'h0000, 1'b0);
        adj = 1'b0; onehz_clk = 1'b0; cyc(2);
        pulse_pause();
        lit("resume", 16'h0000, 1'b1);

        pulse1hz(60);
        lit("sixty", 16'h0100, 1'b1);

        // Set 59:59 through adjust mode, then return to RUN
        adj = 1'b1; sel = 1'b0; cyc(2);
        pulse2hz(58);
        sel = 1'b1; cyc(1);
        pulse2hz(59);
        adj = 1'b0; cyc(2);
        pulse_pause();
        lit("set_5959", 16'h5959, 1'b1);
        pulse1hz(1);
        lit("wrap_all", 16'h0000, 1'b1);

        pulse_pause();
        lit("paused", 16'h0000, 1'b0);
        pulse1hz(5);
        lit("paused_hold", 16'h0000, 1'b0);
        pulse_pause();
        pulse1hz(1);
        lit("unpaused", 16'h0001, 1'b1);

        pulse1hz(9);
        lit("at_0010", 16'h0010, 1'b1);
        pause = 1'b1; onehz_clk = 1'b1; cyc(1);
        pause = 1'b0; cyc(1);
        onehz_clk = 1'b0; cyc(2);
        lit("pause_tick", 16'h0011, 1'b0);

        adj = 1'b1; sel = 1'b0; cyc(2);
        pulse2hz(3);
        sel = 1'b1; cyc(1);
        pulse2hz(47);
        lit("at_0358", 16'h0358, 1'b0);
        blink_clk = 1'b1; cyc(2);
        check("blank_sec_on", 16'(blank_sec), 16'h1);
        check("blank_min_off", 16'(blank_min), 16'h0);
        pulse2hz(3);
        lit("adj_sec_wrap", 16'h0301, 1'b0);
        blink_clk = 1'b0; cyc(2);
        check("blank_sec_off", 16'(blank_sec), 16'h0);
        sel = 1'b0; blink_clk = 1'b1; cyc(2);
        check("blank_min_on", 16'(blank_min), 16'h1);
        check("blank_sec_sel0", 16'(blank_sec), 16'h0);
        sel = 1'b1;

        // Reset mid-ADJ during a 2 Hz edge
        twohz_clk = 1'b1; rst = 1'b1; cyc(1);
        lit("rst_adj", 16'h0000, 1'b1);
        check("rst_adj_blank_min", 16'(blank_min), 16'h0);
        check("rst_adj_blank_sec", 16'(blank_sec), 16'h0);
        rst = 1'b0; adj = 1'b0; twohz_clk = 1'b0; blink_clk = 1'b0; cyc(2);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(2) == 0)  onehz_clk = ~onehz_clk;
            if ($urandom_range(2) == 0)  twohz_clk = ~twohz_clk;
            if ($urandom_range(3) == 0)  blink_clk = ~blink_clk;
            if ($urandom_range(59) == 0) adj = ~adj;
            if ($urandom_range(15) == 0) sel = ~sel;
            pause = ($urandom_range(19) == 0);
            rst   = ($urandom_range(999) == 0);
            cyc(1);
        end
        rst = 1'b0; pause = 1'b0;
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
